// File: rtl/npu_wbuf_pkg.sv
// Shared constants for the weight buffer that serves ADD-mode reads.
//   WBUF_AW     : address width of the weight buffer (13 bits)
//   wbuf_state_t: controller state encoding (INIT=0, READY=1)
//   WBUF_RD_LAT : clocks from a sampled read request to o_rd_valid
package npu_wbuf_pkg;

  localparam int WBUF_AW     = 13;
  localparam int WBUF_RD_LAT = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } wbuf_state_t;

endpackage

// File: rtl/wbuf_sram.sv
// Single-clock 1R1W array with a registered read port and write-first
// bypass: a read and a write to the same address at the same edge return
// the data being written.
// Ports:
//   clk              : clock
//   we, wr_addr, wr_data : write port (caller guarantees wr_addr < DEPTH)
//   re, rd_addr      : read request (caller guarantees rd_addr < DEPTH)
//   rd_data          : registered read data, updated only when re is high
module wbuf_sram #(
  parameter int W     = 64,
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
    if (re) begin
      if (we && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr[IW-1:0]];
      end
    end
  end

endmodule

// File: rtl/wbuf_add_resp.sv
// Weight buffer responder for the ADD-mode weight address generator.
// After reset or i_clear the buffer zero-fills itself (INIT, DEPTH cycles),
// then accepts loader writes (READY). Reads are served in both states with
// a fixed two-register latency; reads during INIT or to an out-of-range
// address return zero.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_clear           : pulse, restart the zero fill
//   i_wr_en/addr/data : loader write port, o_wr_ready qualifies acceptance
//   i_rd_en/addr      : read request
//   o_rd_data/valid   : read response, data held while valid is low
//   o_rd_cnt          : saturating count of returned reads since last init
//   o_addr_err        : sticky out-of-range access flag
//   o_par_err         : parity mismatch on the returned word (only when
//                       WBUF_PARITY_EN is defined)
// Build option: define WBUF_PARITY_EN to store and check an even-parity bit.
module wbuf_add_resp
  import npu_wbuf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_wr_en,
  input  logic [WBUF_AW-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic               o_wr_ready,
  input  logic               i_rd_en,
  input  logic [WBUF_AW-1:0] i_rd_addr,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_rd_valid,
  output logic [15:0]        o_rd_cnt,
  output logic               o_addr_err
`ifdef WBUF_PARITY_EN
  ,
  output logic               o_par_err
`endif
);

`ifdef WBUF_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;

  localparam logic [WBUF_AW:0]   DEPTH_X   = (WBUF_AW+1)'(DEPTH);
  localparam logic [WBUF_AW-1:0] LAST_ADDR = WBUF_AW'(DEPTH - 1);

  function automatic logic addr_ok(input logic [WBUF_AW-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  wbuf_state_t        state, state_nxt;
  logic [WBUF_AW-1:0] fill_cnt;
  logic               fill_last;
  logic               wr_ok;
  logic               mem_we;
  logic [WBUF_AW-1:0] mem_wr_addr;
  logic [MEM_W-1:0]   mem_wr_data;
  logic [MEM_W-1:0]   rd_q_p0;
  logic               vld_p0;
  logic               zero_p0;

  assign o_wr_ready = (state == ST_READY);
  assign fill_last  = (fill_cnt == LAST_ADDR);
  assign wr_ok      = i_wr_en && o_wr_ready && addr_ok(i_wr_addr);

  // The fill owns the write port during INIT; loader writes are only
  // accepted in READY, so the two never compete.
  assign mem_we      = (state == ST_INIT) || wr_ok;
  assign mem_wr_addr = (state == ST_INIT) ? fill_cnt : i_wr_addr;
`ifdef WBUF_PARITY_EN
  assign mem_wr_data = (state == ST_INIT) ? '0 : {^i_wr_data, i_wr_data};
`else
  assign mem_wr_data = (state == ST_INIT) ? '0 : i_wr_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (!i_clear && fill_last) state_nxt = ST_READY;
      ST_READY: if (i_clear) state_nxt = ST_INIT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
    end else if (i_clear) begin
      fill_cnt <= '0;
    end else if (state == ST_INIT) begin
      fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
    end
  end

  // i_clear in either state counts as (re-)entry to INIT for the sticky
  // error flag and the read counter; the clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_addr_err <= 1'b0;
    end else if (i_clear) begin
      o_addr_err <= 1'b0;
    end else if ((i_rd_en && !addr_ok(i_rd_addr)) ||
                 (i_wr_en && !addr_ok(i_wr_addr))) begin
      o_addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rd_cnt <= '0;
    end else if (i_clear) begin
      o_rd_cnt <= '0;
    end else if (o_rd_valid) begin
      o_rd_cnt <= sat_inc(o_rd_cnt);
    end
  end

  // ---- stage p0: array read register ----
  wbuf_sram #(
    .W     (MEM_W),
    .DEPTH (DEPTH),
    .AW    (WBUF_AW)
  ) u_sram (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .re      (i_rd_en && addr_ok(i_rd_addr)),
    .rd_addr (i_rd_addr),
    .rd_data (rd_q_p0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      zero_p0 <= 1'b0;
    end else begin
      vld_p0  <= i_rd_en;
      zero_p0 <= (state == ST_INIT) || !addr_ok(i_rd_addr);
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= vld_p0;
      if (vld_p0) begin
        o_rd_data <= zero_p0 ? '0 : rd_q_p0[DATA_W-1:0];
      end
    end
  end

`ifdef WBUF_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_par_err <= 1'b0;
    end else begin
      o_par_err <= vld_p0 && !zero_p0 && (^rd_q_p0);
    end
  end
`endif

endmodule
